// File: rtl/clkdiv_pkg.sv
// clkdiv shared types and constants.
// Holds the default divider limit, channel state enum and channel ceiling.
package clkdiv_pkg;

  localparam int MAX_CH = 8;
  localparam int unsigned CLKDIV_DEF_LIMIT = 49999;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } ch_state_e;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active and shadow limit, pending flag,
// divided clock and toggle tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int unsigned DEF_LIMIT = CLKDIV_DEF_LIMIT
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_limit,
  output logic             pend,
  output logic             clkout,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(DEF_LIMIT);

  ch_state_e st;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] sh_q, sh_d;
  logic pend_q, pend_d;
  logic clk_q, clk_d;
  logic tick_q, tick_d;
  logic wrap;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lim_q  <= RST_LIM;
      sh_q   <= RST_LIM;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    wrap   = cnt_q >= lim_q;
    st     = !en ? IDLE : (pend_q ? PEND : RUN);
    if (sync) begin
      // Phase alignment: restart from zero and retire any pending limit.
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      if (pend_q) lim_d = sh_q;
      if (wr) lim_d = wr_limit;
    end else begin
      unique case (st)
        IDLE: begin
          pend_d = 1'b0;
          if (pend_q) lim_d = sh_q;
          if (wr) lim_d = wr_limit;
        end
        RUN, PEND: begin
          if (wrap) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
            pend_d = 1'b0;
            if (pend_q) lim_d = sh_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (wr) begin
            sh_d   = wr_limit;
            pend_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pend   = pend_q;
  assign clkout = clk_q;
  assign tick   = tick_q;

endmodule

// File: rtl/clkdiv_sched.sv
// Multi-channel clock divider with glitch-free limit updates.
// Define CLKDIV_SCHED_SYNC_EN to add the sync phase-alignment input.
module clkdiv_sched
  import clkdiv_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CNT_W = 32,
  parameter int unsigned DEF_LIMIT = CLKDIV_DEF_LIMIT
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_ch,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             cfg_ready,
`ifdef CLKDIV_SCHED_SYNC_EN
  input  logic             sync,
`endif
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0]    pend;
  logic [MAX_CH-1:0] pend_x;
  logic              do_sync;

`ifdef CLKDIV_SCHED_SYNC_EN
  assign do_sync = sync;
`else
  assign do_sync = 1'b0;
`endif

  // Indices beyond NCH read as never pending, so they are always accepted.
  always_comb begin
    pend_x = '0;
    pend_x[NCH-1:0] = pend;
  end

  assign cfg_ready = ~pend_x[cfg_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && cfg_ready && (cfg_ch == 3'(i));

    clkdiv_chan #(
      .CNT_W     (CNT_W),
      .DEF_LIMIT (DEF_LIMIT)
    ) u_chan (
      .clkin    (clkin),
      .rst      (rst),
      .en       (ch_en[i]),
      .sync     (do_sync),
      .wr       (wr),
      .wr_limit (cfg_limit),
      .pend     (pend[i]),
      .clkout   (clkout[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Self-checking bench for clkdiv_sched against a behavioural channel model.
// Covers CLKDIV_SCHED_SYNC_EN scenarios when that macro is defined.
module tb_clkdiv_sched;

  localparam int NCH = 4;
  localparam int CNT_W = 32;
  localparam int DEF = 49999;

  logic             clkin = 1'b0;
  logic             rst;
  logic [NCH-1:0]   ch_en;
  logic             cfg_valid;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_limit;
  logic             cfg_ready;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   tick;
`ifdef CLKDIV_SCHED_SYNC_EN
  logic             sync;
`endif

  int n_run = 0;
  int n_fail = 0;

  int unsigned m_cnt [NCH];
  int unsigned m_lim [NCH];
  int unsigned m_sh  [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];

  clkdiv_sched #(
    .NCH       (NCH),
    .CNT_W     (CNT_W),
    .DEF_LIMIT (DEF)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_limit (cfg_limit),
    .cfg_ready (cfg_ready),
`ifdef CLKDIV_SCHED_SYNC_EN
    .sync      (sync),
`endif
    .clkout    (clkout),
    .tick      (tick)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    if (int'(cfg_ch) < NCH) return !m_pend[cfg_ch];
    return 1'b1;
  endfunction

  function automatic logic [NCH-1:0] m_clkv();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_clk[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_tickv();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_tick[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_lim[i] = DEF; m_sh[i] = DEF;
      m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
  endtask

  // One clkin cycle: model follows the behavioural rules, then compare.
  task automatic step();
    bit acc, sy;
    acc = cfg_valid && m_ready();
    sy = 1'b0;
`ifdef CLKDIV_SCHED_SYNC_EN
    sy = sync;
`endif
    @(posedge clkin);
    for (int i = 0; i < NCH; i++) begin
      bit w;
      w = acc && (int'(cfg_ch) == i);
      if (sy) begin
        m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        if (m_pend[i]) m_lim[i] = m_sh[i];
        m_pend[i] = 0;
        if (w) m_lim[i] = cfg_limit;
      end else if (!ch_en[i]) begin
        m_tick[i] = 0;
        if (m_pend[i]) m_lim[i] = m_sh[i];
        m_pend[i] = 0;
        if (w) m_lim[i] = cfg_limit;
      end else begin
        if (m_cnt[i] >= m_lim[i]) begin
          m_cnt[i] = 0; m_clk[i] = !m_clk[i]; m_tick[i] = 1;
          if (m_pend[i]) m_lim[i] = m_sh[i];
          m_pend[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 0;
        end
        if (w) begin m_sh[i] = cfg_limit; m_pend[i] = 1; end
      end
    end
    @(negedge clkin);
    chk("clkout", 32'(clkout), 32'(m_clkv()));
    chk("tick", 32'(tick), 32'(m_tickv()));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
  endtask

  task automatic wait_tick(input int ch, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < bound);
    if (!tick[ch]) chk("tick_timeout", 32'(n), 32'(bound + 1));
  endtask

  task automatic wr(input int ch, input int lim);
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_limit = CNT_W'(lim);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic prev;
    rst = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_limit = '0;
`ifdef CLKDIV_SCHED_SYNC_EN
    sync = 1'b0;
`endif
    m_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_clkout", 32'(clkout), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    @(negedge clkin);
    @(negedge clkin);
    rst = 1'b0;

    // ch0 limit 3: toggles every 4 cycles
    wr(0, 3);
    ch_en = 4'b0001;
    wait_tick(0, 20, n);
    chk("p30_first", 32'(n), 4);
    wait_tick(0, 20, n);
    chk("p30_second", 32'(n), 4);
    chk("p30_others", 32'({clkout[3:1], tick[3:1]}), 0);

    // mid-period lowering to 1 completes the current 4-cycle period
    step();
    step();
    wr(0, 1);
    chk("p31_ready_low", 32'(cfg_ready), 0);
    wait_tick(0, 20, n);
    chk("p31_cur", 32'(n + 3), 4);
    chk("p31_ready_high", 32'(cfg_ready), 1);
    wait_tick(0, 20, n);
    chk("p31_next", 32'(n), 2);
    wait_tick(0, 20, n);
    chk("p31_next2", 32'(n), 2);

    // ch1 idle, limit 0, then enable: toggles every cycle
    wr(1, 0);
    chk("p32_ready", 32'(cfg_ready), 1);
    ch_en = 4'b0011;
    step();
    for (int k = 0; k < 4; k++) begin
      prev = clkout[1];
      step();
      chk("p32_tick", 32'(tick[1]), 1);
      chk("p32_toggle", 32'(clkout[1]), 32'(!prev));
    end

    // out-of-range channel is accepted and discarded
    cfg_ch = 3'd5;
    #1 chk("p33_ready", 32'(cfg_ready), 1);
    wr(5, 7);
    step();

    // reset while a limit is pending
    wr(0, 6);
    chk("p34_pend", 32'(cfg_ready), 0);
    @(posedge clkin);
    #2 rst = 1'b1;
    #1;
    chk("p34_clkout", 32'(clkout), 0);
    chk("p34_tick", 32'(tick), 0);
    chk("p34_ready", 32'(cfg_ready), 1);
    m_reset();
    @(negedge clkin);
    rst = 1'b0;
    ch_en = 4'b0001;
    wait_tick(0, 60000, n);
    chk("p34_period", 32'(n), 32'(DEF + 1));

    // random traffic with small limits
    ch_en = '0;
    step();
    for (int c = 0; c < NCH; c++) wr(c, $urandom_range(0, 7));
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) ch_en = NCH'($urandom);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch = 3'($urandom_range(0, 5));
      cfg_limit = CNT_W'($urandom_range(0, 7));
      step();
    end
    cfg_valid = 1'b0;

`ifdef CLKDIV_SCHED_SYNC_EN
    begin
      int t0, t1;
      ch_en = '0;
      step();
      wr(0, 2);
      wr(1, 5);
      ch_en = 4'b0011;
      for (int k = 0; k < 7; k++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("p35_clk", 32'(clkout[1:0]), 0);
      t0 = 0; t1 = 0;
      for (int k = 1; k <= 8; k++) begin
        step();
        if (tick[0] && t0 == 0) t0 = k;
        if (tick[1] && t1 == 0) t1 = k;
      end
      chk("p35_ch0", 32'(t0), 3);
      chk("p35_ch1", 32'(t1), 6);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
